// File: rtl/trap_pkg.sv
// Shared definitions for the trapezoid rasteriser: FSM state encodings and the
// edge-accumulator width rule.
package trap_pkg;

  typedef logic [2:0] trap_state_t;

  localparam trap_state_t TR_IDLE  = 3'd0;
  localparam trap_state_t TR_LOAD1 = 3'd1;
  localparam trap_state_t TR_LOAD2 = 3'd2;
  localparam trap_state_t TR_LOAD3 = 3'd3;
  localparam trap_state_t TR_SETUP = 3'd4;
  localparam trap_state_t TR_INIT  = 3'd5;
  localparam trap_state_t TR_SCAN  = 3'd6;
  localparam trap_state_t TR_DONE  = 3'd7;

  // Products of two CW+1-bit signed differences plus sign headroom
  function automatic int trap_aw(input int cw);
    return (cw * 32'sd2) + 32'sd2;
  endfunction

endpackage

// File: rtl/trapezoid_raster_if.sv
// Signal bundle for trapezoid_raster: vertex load inputs and the pixel output
// stream with valid/ready handshake.
interface trapezoid_raster_if #(
  parameter int CW = 8
);
  logic          nt;
  logic [CW-1:0] xi;
  logic [CW-1:0] yi;
  logic          po_ready;
  logic          busy;
  logic          po;
  logic [CW-1:0] xo;
  logic [CW-1:0] yo;
  logic          done;

  modport slave  (input nt, xi, yi, po_ready, output busy, po, xo, yo, done);
  modport master (output nt, xi, yi, po_ready, input busy, po, xo, yo, done);
endinterface

// File: rtl/trap_edge_acc.sv
// Edge-function accumulator: the row register holds the value at x=xs of the
// current row; the pixel register steps by +H along a row and reloads on row change.
module trap_edge_acc #(
  parameter int AW = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 x_step,
  input  logic                 row_step,
  input  logic signed [AW-1:0] init_val,
  input  logic signed [AW-1:0] h,
  input  logic signed [AW-1:0] d,
  output logic                 neg,
  output logic                 zero
);
  logic signed [AW-1:0] row_r;
  logic signed [AW-1:0] pix_r;
  logic signed [AW-1:0] row_nxt_s;

  assign row_nxt_s = row_r - d;

  // Accumulator update; init wins over either step
  always_ff @(posedge clk) begin
    if (reset) begin
      row_r <= {AW{1'b0}};
      pix_r <= {AW{1'b0}};
    end else if (init) begin
      row_r <= init_val;
      pix_r <= init_val;
    end else if (row_step) begin
      row_r <= row_nxt_s;
      pix_r <= row_nxt_s;
    end else if (x_step) begin
      pix_r <= pix_r + h;
    end
  end

  assign neg  = pix_r[AW-1];
  assign zero = (pix_r == {AW{1'b0}});

endmodule

// File: rtl/trapezoid_raster.sv
// Trapezoid rasteriser: loads four vertices, then streams every covered pixel in
// raster order over a valid/ready port using add-only edge-function stepping.
module trapezoid_raster #(
  parameter int CW = 8
) (
  input logic               clk,
  input logic               reset,
  trapezoid_raster_if.slave bus
);
  import trap_pkg::*;

  localparam int AW = trap_aw(CW);
  localparam logic [CW-1:0] CW_ONE = {{(CW-1){1'b0}}, 1'b1};

  trap_state_t          state_r;
  logic [CW-1:0]        xul_r, xur_r, xdl_r, xdr_r, yu_r, yd_r;
  logic [CW-1:0]        xs_r, xe_r, x_r, y_r, xo_r, yo_r;
  logic signed [AW-1:0] h_r, dl_r, dr_r;
  logic                 busy_r, po_r;

  logic [CW-1:0]        xs_s, xe_s;
  logic                 empty_s, slot_free_s, incl_s, row_end_s, last_row_s;
  logic                 acc_init_s, acc_xstep_s, acc_rowstep_s;
  logic signed [AW-1:0] l_init_s, r_init_s;
  logic                 l_neg_s, l_zero_s, r_neg_s, r_zero_s;

  function automatic logic signed [AW-1:0] ext(input logic [CW-1:0] v);
    return signed'({{(AW-CW){1'b0}}, v});
  endfunction

  assign xs_s        = (xdl_r < xul_r) ? xdl_r : xul_r;
  assign xe_s        = (xdr_r > xur_r) ? xdr_r : xur_r;
  assign empty_s     = (yu_r < yd_r) || (xs_s > xe_s);
  assign slot_free_s = !po_r || bus.po_ready;
  assign incl_s      = (l_zero_s || !l_neg_s) && (r_zero_s || r_neg_s);
  assign row_end_s   = (x_r == xe_r);
  assign last_row_s  = (y_r == yu_r);

  // Edge values at (xs, yd); the only multiplies in the design
  assign l_init_s = (ext(xs_r) - ext(xdl_r)) * h_r;
  assign r_init_s = (ext(xs_r) - ext(xdr_r)) * h_r;

  assign acc_init_s    = (state_r == TR_INIT);
  assign acc_xstep_s   = (state_r == TR_SCAN) && slot_free_s && !row_end_s;
  assign acc_rowstep_s = (state_r == TR_SCAN) && slot_free_s && row_end_s && !last_row_s;

  trap_edge_acc #(.AW(AW)) u_left (
    .clk      (clk),
    .reset    (reset),
    .init     (acc_init_s),
    .x_step   (acc_xstep_s),
    .row_step (acc_rowstep_s),
    .init_val (l_init_s),
    .h        (h_r),
    .d        (dl_r),
    .neg      (l_neg_s),
    .zero     (l_zero_s)
  );

  trap_edge_acc #(.AW(AW)) u_right (
    .clk      (clk),
    .reset    (reset),
    .init     (acc_init_s),
    .x_step   (acc_xstep_s),
    .row_step (acc_rowstep_s),
    .init_val (r_init_s),
    .h        (h_r),
    .d        (dr_r),
    .neg      (r_neg_s),
    .zero     (r_zero_s)
  );

  // Sequencer: vertex capture, setup, scan counters and the registered pixel slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TR_IDLE;
      xul_r   <= {CW{1'b0}};
      xur_r   <= {CW{1'b0}};
      xdl_r   <= {CW{1'b0}};
      xdr_r   <= {CW{1'b0}};
      yu_r    <= {CW{1'b0}};
      yd_r    <= {CW{1'b0}};
      xs_r    <= {CW{1'b0}};
      xe_r    <= {CW{1'b0}};
      x_r     <= {CW{1'b0}};
      y_r     <= {CW{1'b0}};
      xo_r    <= {CW{1'b0}};
      yo_r    <= {CW{1'b0}};
      h_r     <= {AW{1'b0}};
      dl_r    <= {AW{1'b0}};
      dr_r    <= {AW{1'b0}};
      busy_r  <= 1'b0;
      po_r    <= 1'b0;
    end else begin
      case (state_r)
        TR_IDLE: begin
          if (bus.nt) begin
            xul_r   <= bus.xi;
            yu_r    <= bus.yi;
            busy_r  <= 1'b1;
            state_r <= TR_LOAD1;
          end
        end
        TR_LOAD1: begin
          xur_r   <= bus.xi;
          state_r <= TR_LOAD2;
        end
        TR_LOAD2: begin
          xdl_r   <= bus.xi;
          yd_r    <= bus.yi;
          state_r <= TR_LOAD3;
        end
        TR_LOAD3: begin
          xdr_r   <= bus.xi;
          state_r <= TR_SETUP;
        end
        TR_SETUP: begin
          xs_r    <= xs_s;
          xe_r    <= xe_s;
          h_r     <= ext(yu_r) - ext(yd_r);
          dl_r    <= ext(xul_r) - ext(xdl_r);
          dr_r    <= ext(xur_r) - ext(xdr_r);
          state_r <= empty_s ? TR_DONE : TR_INIT;
        end
        TR_INIT: begin
          x_r     <= xs_r;
          y_r     <= yd_r;
          state_r <= TR_SCAN;
        end
        TR_SCAN: begin
          if (slot_free_s) begin
            po_r <= incl_s;
            if (incl_s) begin
              xo_r <= x_r;
              yo_r <= y_r;
            end
            if (!row_end_s) begin
              x_r <= x_r + CW_ONE;
            end else if (!last_row_s) begin
              x_r <= xs_r;
              y_r <= y_r + CW_ONE;
            end else begin
              state_r <= TR_DONE;
            end
          end
        end
        TR_DONE: begin
          if (slot_free_s) begin
            po_r    <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= TR_IDLE;
          end
        end
        default: begin
          state_r <= TR_IDLE;
        end
      endcase
    end
  end

  // done coincides with acceptance of the final pixel, so it follows po_ready
  assign bus.done = (state_r == TR_DONE) && slot_free_s;
  assign bus.busy = busy_r;
  assign bus.po   = po_r;
  assign bus.xo   = xo_r;
  assign bus.yo   = yo_r;

endmodule

// File: tb/tb_trapezoid_raster.sv
// Directed bench for trapezoid_raster: a reference model fills a pixel scoreboard
// that is drained as the DUT hands pixels over the valid/ready port.
module tb_trapezoid_raster;
  localparam int TB_CW = 10;

  logic clk = 1'b0;
  logic reset;

  trapezoid_raster_if #(.CW(TB_CW)) bus ();

  trapezoid_raster #(.CW(TB_CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y);
    logic [31:0] r;
    r = {x[15:0], y[15:0]};
    return r;
  endfunction

  // Direct evaluation of the inclusion rule at every candidate
  task automatic model_push(input int xul, input int yu, input int xur,
                            input int xdl, input int yd, input int xdr, output int n);
    int xs, xe, h, dl, dr;
    longint l, r;
    n  = 0;
    xs = (xdl < xul) ? xdl : xul;
    xe = (xdr > xur) ? xdr : xur;
    h  = yu - yd;
    dl = xul - xdl;
    dr = xur - xdr;
    if (yu >= yd && xs <= xe) begin
      for (int y = yd; y <= yu; y++) begin
        for (int x = xs; x <= xe; x++) begin
          l = longint'(x - xdl) * longint'(h) - longint'(dl) * longint'(y - yd);
          r = longint'(x - xdr) * longint'(h) - longint'(dr) * longint'(y - yd);
          if (l >= 0 && r <= 0) begin
            exp_q.push_back(pk(x, y));
            n++;
          end
        end
      end
    end
  endtask

  task automatic start_shape(input int xul, input int yu, input int xur,
                             input int xdl, input int yd, input int xdr);
    @(negedge clk);
    check("idle_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    bus.nt = 1'b1; bus.xi = TB_CW'(xul); bus.yi = TB_CW'(yu);
    @(negedge clk);
    check("busy_rise", {31'd0, bus.busy}, 32'd1);
    bus.nt = 1'b0; bus.xi = TB_CW'(xur); bus.yi = TB_CW'(1023);
    @(negedge clk);
    bus.nt = 1'b1; bus.xi = TB_CW'(xdl); bus.yi = TB_CW'(yd);
    @(negedge clk);
    bus.nt = 1'b0; bus.xi = TB_CW'(xdr); bus.yi = TB_CW'(0);
  endtask

  // Iteration n observes cycle T+4+n; mode 1 stalls with a 1-0-0 ready pattern
  task automatic run_shape(input string name, input int mode, input int done_at,
                           input int exp_n, output logic [31:0] last_xy);
    int n = 0;
    int got = 0;
    bit fin = 1'b0;
    last_xy = 32'd0;
    while (!fin && n < 40000) begin
      @(negedge clk);
      bus.po_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      #1;
      if (bus.po) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_pixel"}, pk(int'(bus.xo), int'(bus.yo)), 32'hFFFF_FFFF);
        end else begin
          check({name, "_pixel"}, pk(int'(bus.xo), int'(bus.yo)), exp_q[0]);
          if (bus.po_ready) begin
            last_xy = pk(int'(bus.xo), int'(bus.yo));
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (bus.done) begin
        fin = 1'b1;
        if (done_at >= 0) check({name, "_done_cycle"}, n, done_at);
        check({name, "_count"}, got, exp_n);
        check({name, "_queue_empty"}, exp_q.size(), 32'd0);
      end
      n++;
    end
    if (!fin) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n, cnt, k;
    logic [31:0] lxy;
    reset = 1'b1;
    bus.nt = 1'b0; bus.xi = '0; bus.yi = '0; bus.po_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_flags", {29'd0, bus.busy, bus.po, bus.done}, 32'd0);
    check("rst_xy", pk(int'(bus.xo), int'(bus.yo)), 32'd0);
    reset = 1'b0;

    model_push(2, 3, 5, 1, 0, 6, n);
    start_shape(2, 3, 5, 1, 0, 6);
    run_shape("basic", 0, 26, 18, lxy);

    model_push(0, 1, 3, 0, 0, 3, n);
    start_shape(0, 1, 3, 0, 0, 3);
    run_shape("rect", 0, 10, 8, lxy);
    check("rect_last", lxy, pk(3, 1));

    model_push(3, 4, 7, 1, 4, 5, n);
    start_shape(3, 4, 7, 1, 4, 5);
    run_shape("flat", 0, 9, 7, lxy);
    check("flat_last", lxy, pk(7, 4));

    model_push(1, 2, 4, 1, 5, 4, n);
    start_shape(1, 2, 4, 1, 5, 4);
    run_shape("empty", 0, 1, 0, lxy);

    model_push(2, 3, 5, 1, 0, 6, n);
    start_shape(2, 3, 5, 1, 0, 6);
    run_shape("stall", 1, -1, 18, lxy);
    check("stall_last", lxy, pk(5, 3));

    start_shape(2, 3, 5, 1, 0, 6);
    cnt = 0; k = 0;
    while (cnt < 5 && k < 60) begin
      @(negedge clk);
      bus.po_ready = 1'b1;
      #1;
      if (bus.po) cnt++;
      k++;
    end
    check("rst_mid_reached", cnt, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_flags", {29'd0, bus.busy, bus.po, bus.done}, 32'd0);
    check("rst_mid_xy", pk(int'(bus.xo), int'(bus.yo)), 32'd0);
    reset = 1'b0;

    model_push(0, 1, 3, 0, 0, 3, n);
    start_shape(0, 1, 3, 0, 0, 3);
    run_shape("post_rst", 0, 10, 8, lxy);

    model_push(511, 1, 511, 0, 0, 1023, n);
    start_shape(511, 1, 511, 0, 0, 1023);
    run_shape("wide", 0, 2050, 1025, lxy);
    check("wide_apex", lxy, pk(511, 1));

    model_push(1011, 1023, 1011, 1000, 0, 1023, n);
    start_shape(1011, 1023, 1011, 1000, 0, 1023);
    run_shape("tall", 0, 24578, n, lxy);
    check("tall_apex", lxy, pk(1011, 1023));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
